// File: rtl/vn_extrinsic_sub_if.sv
// vn_extrinsic_sub_if
//   Handshake bundle between a variable-node extrinsic extractor and its
//   neighbours.
//   Input side : llr_in, msg_in, in_valid (to block), in_ready (from block)
//   Output side: out_msg, out_valid, out_last, out_hard (from block),
//                out_ready (to block)
//   master : the environment that feeds messages and consumes extrinsics
//   slave  : the extractor itself
interface vn_extrinsic_sub_if #(
  parameter int W = 6
) ();
  logic [W-1:0] llr_in;
  logic [W-1:0] msg_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_msg;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_hard;

  modport master (
    output llr_in, msg_in, in_valid, out_ready,
    input  in_ready, out_msg, out_valid, out_last, out_hard
  );

  modport slave (
    input  llr_in, msg_in, in_valid, out_ready,
    output in_ready, out_msg, out_valid, out_last, out_hard
  );
endinterface

// File: rtl/vn_extrinsic_sub.sv
// vn_extrinsic_sub
//   Variable-node extrinsic extractor. Collects one channel LLR plus DEG
//   check-to-variable messages into a full-precision total, then emits DEG
//   saturated extrinsics (total minus own message) with the hard decision.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : slave side of vn_extrinsic_sub_if (input beats / output beats)
module vn_extrinsic_sub #(
  parameter int W   = 6,
  parameter int DEG = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  vn_extrinsic_sub_if.slave     bus
);

  // Accumulator wide enough for any total and any total minus one message.
  localparam int A  = W + $clog2(DEG + 1) + 1;
  localparam int CW = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEG - 1);
  localparam logic [CW-1:0] FIRST_IDX = {CW{1'b0}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic signed [A-1:0] acc_r, acc_nxt_s, acc_sum_s;
  logic [CW-1:0]       in_cnt_r, in_cnt_nxt_s;
  logic [CW-1:0]       out_cnt_r, out_cnt_nxt_s, out_idx_s;
  logic [W-1:0]        msg_buf_r [DEG];
  logic [W-1:0]        out_msg_r, out_msg_nxt_s;
  logic                out_last_r, out_last_nxt_s;
  logic                out_hard_r, out_hard_nxt_s;

  function automatic logic signed [A-1:0] sext(input logic [W-1:0] v);
    return {{(A-W){v[W-1]}}, v};
  endfunction

  // In range exactly when all bits above the W-bit sign agree with it.
  function automatic logic [W-1:0] sat(input logic signed [A-1:0] v);
    logic [W-1:0] r;
    if (v[A-1:W-1] == {(A-W+1){v[A-1]}}) begin
      r = v[W-1:0];
    end else if (v[A-1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  assign bus.in_ready  = (state_r == ST_ACCUM);
  assign bus.out_valid = (state_r == ST_EMIT);
  assign bus.out_msg   = out_msg_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_hard  = out_hard_r;

  assign out_idx_s = out_cnt_r + CW'(1'b1);

  // Running total including the beat being accepted this cycle.
  always_comb begin
    acc_sum_s = acc_r;
    if (in_cnt_r == FIRST_IDX) begin
      acc_sum_s = sext(bus.llr_in) + sext(bus.msg_in);
    end else begin
      acc_sum_s = acc_r + sext(bus.msg_in);
    end
  end

  // Next-state and next-output logic for the accumulate/emit sequence.
  always_comb begin
    state_nxt_s    = state_r;
    acc_nxt_s      = acc_r;
    in_cnt_nxt_s   = in_cnt_r;
    out_cnt_nxt_s  = out_cnt_r;
    out_msg_nxt_s  = out_msg_r;
    out_last_nxt_s = out_last_r;
    out_hard_nxt_s = out_hard_r;
    case (state_r)
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_nxt_s = acc_sum_s;
          if (in_cnt_r == LAST_IDX) begin
            // First extrinsic must use the total that includes this beat.
            in_cnt_nxt_s   = FIRST_IDX;
            out_cnt_nxt_s  = FIRST_IDX;
            state_nxt_s    = ST_EMIT;
            out_msg_nxt_s  = sat(acc_sum_s - sext(msg_buf_r[FIRST_IDX]));
            out_last_nxt_s = (LAST_IDX == FIRST_IDX);
            out_hard_nxt_s = acc_sum_s[A-1];
          end else begin
            in_cnt_nxt_s = in_cnt_r + CW'(1'b1);
          end
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (out_cnt_r == LAST_IDX) begin
            out_cnt_nxt_s  = FIRST_IDX;
            state_nxt_s    = ST_ACCUM;
            out_msg_nxt_s  = {W{1'b0}};
            out_last_nxt_s = 1'b0;
            out_hard_nxt_s = 1'b0;
          end else begin
            out_cnt_nxt_s  = out_idx_s;
            out_msg_nxt_s  = sat(acc_r - sext(msg_buf_r[out_idx_s]));
            out_last_nxt_s = (out_idx_s == LAST_IDX);
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s = ST_ACCUM;
      end
    endcase
  end

  // State, accumulator, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_ACCUM;
      acc_r      <= {A{1'b0}};
      in_cnt_r   <= {CW{1'b0}};
      out_cnt_r  <= {CW{1'b0}};
      out_msg_r  <= {W{1'b0}};
      out_last_r <= 1'b0;
      out_hard_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      acc_r      <= acc_nxt_s;
      in_cnt_r   <= in_cnt_nxt_s;
      out_cnt_r  <= out_cnt_nxt_s;
      out_msg_r  <= out_msg_nxt_s;
      out_last_r <= out_last_nxt_s;
      out_hard_r <= out_hard_nxt_s;
    end
  end

  // Per-node message store, written on every accepted input beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEG; i++) begin
        msg_buf_r[i] <= {W{1'b0}};
      end
    end else if ((state_r == ST_ACCUM) && bus.in_valid) begin
      msg_buf_r[in_cnt_r] <= bus.msg_in;
    end
  end

endmodule

// File: tb/tb_vn_extrinsic_sub.sv
module tb_vn_extrinsic_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  vn_extrinsic_sub_if #(.W(6)) bus ();

  vn_extrinsic_sub #(.W(6), .DEG(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Results gathered by the stimulus/collection tasks
  int got_msg [3];
  bit got_last[3];
  bit got_hard[3];
  int n_got;
  int first_wait;
  bit ready_in_emit;
  bit stall_unstable;
  int last_out_cyc;
  int first_in_cyc;

  // Reference model: plain integer arithmetic on the node's values
  function automatic int sat_ref(int v);
    if (v > 31) return 31;
    else if (v < -32) return -32;
    else return v;
  endfunction

  function automatic int ext_ref(int llr, int m[3], int k);
    return sat_ref(llr + m[0] + m[1] + m[2] - m[k]);
  endfunction

  function automatic bit hard_ref(int llr, int m[3]);
    return (llr + m[0] + m[1] + m[2]) < 0;
  endfunction

  // Feed nbeats input beats; gap_mode 0=none, 1=one idle cycle between beats, 2=random idles
  task automatic send_node(input int llr, input int m[3], input int nbeats, input int gap_mode);
    int guard;
    bit done;
    for (int i = 0; i < nbeats; i++) begin
      int idles;
      idles = (i == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idles) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.llr_in   = 6'($urandom);
        bus.msg_in   = 6'($urandom);
      end
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.llr_in   = (i == 0) ? 6'(llr) : 6'($urandom);
        bus.msg_in   = 6'(m[i]);
        if (bus.in_ready === 1'b1) begin
          if (i == 0) first_in_cyc = cyc;
          done = 1'b1;
        end else begin
          guard++;
          if (guard > 100) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready stuck at %b for beat %0d, required 1", bus.in_ready, i);
            done = 1'b1;
          end
        end
      end
    end
  endtask

  // Drain one node's outputs, applying a stall window or random out_ready
  task automatic collect_node(input int stall_beat, input int stall_len, input bit rnd_ready, input bit hold_valid);
    int guard = 0;
    int stalled = 0;
    bit have_prev = 1'b0;
    bit seen = 1'b0;
    bit rdy;
    logic [5:0] pm;
    logic pl, ph;
    n_got = 0; first_wait = 0; ready_in_emit = 1'b0; stall_unstable = 1'b0;
    while (n_got < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (hold_valid) begin
        bus.in_valid = 1'b1;
        bus.msg_in   = 6'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
      else if (n_got == stall_beat && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else rdy = 1'b1;
      bus.out_ready = rdy;
      if (bus.out_valid !== 1'b1) begin
        if (!seen) first_wait++;
        have_prev = 1'b0;
      end else begin
        seen = 1'b1;
        if (bus.in_ready !== 1'b0) ready_in_emit = 1'b1;
        if (have_prev && (bus.out_msg !== pm || bus.out_last !== pl || bus.out_hard !== ph))
          stall_unstable = 1'b1;
        if (rdy) begin
          got_msg[n_got]  = int'($signed(bus.out_msg));
          got_last[n_got] = bus.out_last;
          got_hard[n_got] = bus.out_hard;
          if (n_got == 2) last_out_cyc = cyc;
          n_got++;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          pm = bus.out_msg; pl = bus.out_last; ph = bus.out_hard;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.llr_in = 6'd0; bus.msg_in = 6'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin tests_failed++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid); end
    tests_run++;
    if (bus.out_msg !== 6'd0 || bus.out_last !== 1'b0 || bus.out_hard !== 1'b0)
      begin tests_failed++; $display("FAIL reset_outputs: msg=%0d last=%b hard=%b, required 0/0/0", bus.out_msg, bus.out_last, bus.out_hard); end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    int exp_m[3] = '{10, 15, 6};
    send_node(5, '{3, -2, 7}, 3, 0);
    collect_node(-1, 0, 1'b0, 1'b0);
    tests_run++;
    if (n_got !== 3 || first_wait !== 0)
      begin tests_failed++; $display("FAIL nominal_latency: beats=%0d wait=%0d, required 3/0", n_got, first_wait); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got_msg[k] !== exp_m[k] || got_last[k] !== (k == 2) || got_hard[k] !== 1'b0)
        begin tests_failed++; $display("FAIL nominal_beat%0d: msg=%0d last=%b hard=%b, required %0d/%b/0", k, got_msg[k], got_last[k], got_hard[k], exp_m[k], k == 2); end
    end
  endtask

  task automatic test_pos_sat;
    int exp_m[3] = '{30, 30, 31};
    send_node(31, '{31, 31, -32}, 3, 0);
    collect_node(-1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got_msg[k] !== exp_m[k] || got_hard[k] !== 1'b0 || got_last[k] !== (k == 2))
        begin tests_failed++; $display("FAIL pos_sat_beat%0d: msg=%0d hard=%b last=%b, required %0d/0/%b", k, got_msg[k], got_hard[k], got_last[k], exp_m[k], k == 2); end
    end
  endtask

  task automatic test_neg_sat;
    send_node(-32, '{-32, -32, -32}, 3, 0);
    collect_node(-1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got_msg[k] !== -32 || got_hard[k] !== 1'b1)
        begin tests_failed++; $display("FAIL neg_sat_beat%0d: msg=%0d hard=%b, required -32/1", k, got_msg[k], got_hard[k]); end
    end
  endtask

  task automatic test_backpressure;
    int exp_m[3] = '{10, 15, 6};
    send_node(5, '{3, -2, 7}, 3, 1);
    collect_node(1, 4, 1'b0, 1'b0);
    tests_run++;
    if (stall_unstable !== 1'b0 || ready_in_emit !== 1'b0)
      begin tests_failed++; $display("FAIL bp_stability: unstable=%b in_ready_in_emit=%b, required 0/0", stall_unstable, ready_in_emit); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got_msg[k] !== exp_m[k] || got_last[k] !== (k == 2))
        begin tests_failed++; $display("FAIL bp_beat%0d: msg=%0d last=%b, required %0d/%b", k, got_msg[k], got_last[k], exp_m[k], k == 2); end
    end
  endtask

  task automatic test_reset_mid;
    int exp_m[3] = '{5, 4, 3};
    for (int phase = 0; phase < 2; phase++) begin
      // phase 0: abort during input; phase 1: abort while outputs pending
      send_node(5, '{3, -2, 7}, (phase == 0) ? 2 : 3, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_msg !== 6'd0 || bus.out_last !== 1'b0 || bus.out_hard !== 1'b0)
        begin tests_failed++; $display("FAIL reset_mid%0d: rdy=%b vld=%b msg=%0d last=%b hard=%b, required 1/0/0/0/0", phase, bus.in_ready, bus.out_valid, bus.out_msg, bus.out_last, bus.out_hard); end
      @(negedge clk);
      rst = 1'b0;
      send_node(0, '{1, 2, 3}, 3, 0);
      collect_node(-1, 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (got_msg[k] !== exp_m[k] || got_last[k] !== (k == 2) || got_hard[k] !== 1'b0)
          begin tests_failed++; $display("FAIL reset_mid%0d_beat%0d: msg=%0d last=%b hard=%b, required %0d/%b/0", phase, k, got_msg[k], got_last[k], got_hard[k], exp_m[k], k == 2); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int exp_m[3] = '{10, 15, 6};
    int end_cyc;
    send_node(5, '{3, -2, 7}, 3, 0);
    collect_node(-1, 0, 1'b0, 1'b1);
    end_cyc = last_out_cyc;
    send_node(5, '{3, -2, 7}, 3, 0);
    tests_run++;
    if (first_in_cyc - end_cyc !== 1)
      begin tests_failed++; $display("FAIL b2b_gap: next input %0d cycles after last output, required 1", first_in_cyc - end_cyc); end
    collect_node(-1, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got_msg[k] !== exp_m[k] || got_last[k] !== (k == 2) || got_hard[k] !== 1'b0)
        begin tests_failed++; $display("FAIL b2b_beat%0d: msg=%0d last=%b hard=%b, required %0d/%b/0", k, got_msg[k], got_last[k], got_hard[k], exp_m[k], k == 2); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      int llr;
      int m[3];
      llr = int'($urandom_range(0, 63)) - 32;
      for (int k = 0; k < 3; k++) m[k] = int'($urandom_range(0, 63)) - 32;
      send_node(llr, m, 3, 2);
      collect_node(-1, 0, 1'b1, 1'b0);
      tests_run++;
      if (n_got !== 3 || first_wait !== 0 || stall_unstable !== 1'b0 || ready_in_emit !== 1'b0)
        begin tests_failed++; $display("FAIL rand%0d_flow: beats=%0d wait=%0d unstable=%b rdy_emit=%b, required 3/0/0/0", n, n_got, first_wait, stall_unstable, ready_in_emit); end
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (got_msg[k] !== ext_ref(llr, m, k) || got_last[k] !== (k == 2) || got_hard[k] !== hard_ref(llr, m))
          begin tests_failed++; $display("FAIL rand%0d_beat%0d: msg=%0d last=%b hard=%b, required %0d/%b/%b", n, k, got_msg[k], got_last[k], got_hard[k], ext_ref(llr, m, k), k == 2, hard_ref(llr, m)); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_pos_sat;
    test_neg_sat;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
